// File: rtl/dump_pkg.sv
// Shared types and helpers for the channel dump sequencer.
package dump_pkg;

   // Sequencer states, in the order a dump walks through them.
   typedef enum logic [3:0] {
      IDLE,
      RD_OFF,
      WT_OFF,
      RD_GAIN,
      WT_GAIN,
      RD_RAM,
      SEND,
      WT_TX,
      DONE
   } dump_state_t;

   // Channel code that has no capture bank behind it.
   localparam logic [1:0] CH_RSVD = 2'b11;

   // Calibration EEPROM address width.
   localparam int EEP_AW = 6;

   // Calibration EEPROM layout: one offset/gain byte pair per channel and AFE gain step.
   // The offset byte sits at the even address and the gain byte at the odd address.
   function automatic logic [EEP_AW-1:0] cal_addr(input logic [1:0] ch,
                                                  input logic [2:0] g,
                                                  input logic       is_gain);
      return {ch, g, is_gain};
   endfunction

endpackage : dump_pkg

// File: rtl/dump_addr_gen.sv
// Capture RAM read address generator: a wrapping address register plus a byte
// counter that flags the final byte of a full-depth dump.
module dump_addr_gen #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   // Next address/count: load restarts at the oldest sample, inc steps one byte.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load) begin
         addr_d = start_addr;
         cnt_d  = '0;
      end else if (inc) begin
         // DEPTH is a power of two, so the natural ADDR_W-bit rollover is the wrap to 0.
         addr_d = addr_q + 1'b1;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   // Address and count registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr = addr_q;
   // The byte currently in flight is the last one when DEPTH-1 bytes are already done.
   assign last = (cnt_q == LAST_CNT);

endmodule : dump_addr_gen

// File: rtl/dump_ctrl.sv
// Channel dump sequencer: fetches offset and gain calibration bytes from the
// EEPROM, then streams every capture RAM entry of the channel, oldest first,
// to the UART transmitter.
module dump_ctrl
   import dump_pkg::*;
#(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dump,
   input  logic [1:0]        dump_ch,
   input  logic [2:0]        ch1_AFEgain,
   input  logic [2:0]        ch2_AFEgain,
   input  logic [2:0]        ch3_AFEgain,
   input  logic [ADDR_W-1:0] wr_ptr,
   output logic              eep_req,
   output logic [EEP_AW-1:0] eep_addr,
   input  logic              eep_done,
   output logic              flopOffset,
   output logic              flopGain,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [1:0]        ram_ch,
   output logic              ram_re,
   output logic              send_resp,
   input  logic              resp_sent,
   output logic              busy,
   output logic              dump_done,
   output logic              dump_err
);

   dump_state_t state_q, state_d;
   logic [1:0]  ch_q, ch_d;
   logic [2:0]  gain_q, gain_d;
   logic        err_q, err_d;

   logic [2:0]  sel_gain;
   logic        accept;
   logic        addr_load;
   logic        addr_inc;
   logic        addr_last;

   // A dump request only starts a sequence from IDLE and for a real channel.
   assign accept = (state_q == IDLE) && dump && (dump_ch != CH_RSVD);

   // AFE gain of the channel being requested, captured on acceptance.
   always_comb begin
      sel_gain = ch3_AFEgain;
      case (dump_ch)
         2'd0:    sel_gain = ch1_AFEgain;
         2'd1:    sel_gain = ch2_AFEgain;
         default: sel_gain = ch3_AFEgain;
      endcase
   end

   // State, latched channel/gain and the error strobe register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         gain_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         gain_q  <= gain_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; channel and gain are frozen for the whole dump.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      gain_d  = gain_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (dump && (dump_ch == CH_RSVD)) begin
               err_d = 1'b1;
            end else if (accept) begin
               ch_d    = dump_ch;
               gain_d  = sel_gain;
               state_d = RD_OFF;
            end
         end
         RD_OFF:  state_d = WT_OFF;
         WT_OFF:  if (eep_done) state_d = RD_GAIN;
         RD_GAIN: state_d = WT_GAIN;
         WT_GAIN: if (eep_done) state_d = RD_RAM;
         RD_RAM:  state_d = SEND;
         SEND:    state_d = WT_TX;
         WT_TX: begin
            if (resp_sent) state_d = addr_last ? DONE : RD_RAM;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode; EEPROM address is driven only alongside its request.
   always_comb begin
      eep_req    = 1'b0;
      eep_addr   = '0;
      flopOffset = 1'b0;
      flopGain   = 1'b0;
      ram_re     = 1'b0;
      send_resp  = 1'b0;
      dump_done  = 1'b0;
      addr_load  = accept;
      addr_inc   = 1'b0;
      case (state_q)
         RD_OFF: begin
            eep_req  = 1'b1;
            eep_addr = cal_addr(ch_q, gain_q, 1'b0);
         end
         WT_OFF:  flopOffset = eep_done;
         RD_GAIN: begin
            eep_req  = 1'b1;
            eep_addr = cal_addr(ch_q, gain_q, 1'b1);
         end
         WT_GAIN: flopGain  = eep_done;
         RD_RAM:  ram_re    = 1'b1;
         SEND:    send_resp = 1'b1;
         WT_TX:   addr_inc  = resp_sent;
         DONE:    dump_done = 1'b1;
         default: ;
      endcase
   end

   dump_addr_gen #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .load       (addr_load),
      .inc        (addr_inc),
      .start_addr (wr_ptr),
      .addr       (ram_addr),
      .last       (addr_last)
   );

   assign ram_ch   = ch_q;
   assign busy     = (state_q != IDLE);
   assign dump_err = err_q;

endmodule : dump_ctrl

// File: tb/tb_dump_ctrl.sv
// Self-checking bench for dump_ctrl: handshake responders, a bus monitor and a
// reference model of the expected EEPROM addresses, RAM walk and timing.
module tb_dump_ctrl;

   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              rst;
   logic              dump;
   logic [1:0]        dump_ch;
   logic [2:0]        ch1_AFEgain, ch2_AFEgain, ch3_AFEgain;
   logic [ADDR_W-1:0] wr_ptr;
   logic              eep_req;
   logic [5:0]        eep_addr;
   logic              eep_done;
   logic              flopOffset, flopGain;
   logic [ADDR_W-1:0] ram_addr;
   logic [1:0]        ram_ch;
   logic              ram_re, send_resp, resp_sent;
   logic              busy, dump_done, dump_err;

   dump_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .dump        (dump),
      .dump_ch     (dump_ch),
      .ch1_AFEgain (ch1_AFEgain),
      .ch2_AFEgain (ch2_AFEgain),
      .ch3_AFEgain (ch3_AFEgain),
      .wr_ptr      (wr_ptr),
      .eep_req     (eep_req),
      .eep_addr    (eep_addr),
      .eep_done    (eep_done),
      .flopOffset  (flopOffset),
      .flopGain    (flopGain),
      .ram_addr    (ram_addr),
      .ram_ch      (ram_ch),
      .ram_re      (ram_re),
      .send_resp   (send_resp),
      .resp_sent   (resp_sent),
      .busy        (busy),
      .dump_done   (dump_done),
      .dump_err    (dump_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Responder configuration.
   int eep_dly  = 1;
   int resp_min = 1;
   int resp_max = 1;
   bit spur_en  = 1'b0;

   // Monitor state.
   logic [1:0] exp_ch;
   int send_q[$];
   int eep_q[$];
   int flop_q[$];
   int done_cnt, err_cnt, busy_cnt, ch_bad, send_bad;
   int done_cyc, err_cyc, eep_cyc_first, dump_cyc;
   int re_addr;
   bit prev_re, gain_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({eep_req, eep_addr, flopOffset, flopGain, ram_addr, ram_ch,
                  ram_re, send_resp, busy, dump_done, dump_err});
   endfunction

   task automatic clear_mon();
      send_q.delete();
      eep_q.delete();
      flop_q.delete();
      done_cnt = 0; err_cnt = 0; busy_cnt = 0; ch_bad = 0; send_bad = 0;
      done_cyc = -1; err_cyc = -1; eep_cyc_first = -1;
      prev_re = 1'b0; gain_seen = 1'b0; re_addr = -1;
   endtask

   // EEPROM / UART responders: answer each request after a configurable delay and
   // optionally throw in strobes where the sequencer is not waiting for them.
   int  eep_wait, resp_wait;
   bit  eep_pend, resp_pend;
   initial begin
      eep_done = 1'b0; resp_sent = 1'b0; eep_pend = 1'b0; resp_pend = 1'b0;
      eep_wait = 0; resp_wait = 0;
      forever begin
         @(negedge clk);
         eep_done  = 1'b0;
         resp_sent = 1'b0;
         if (rst) begin
            eep_pend  = 1'b0;
            resp_pend = 1'b0;
         end else begin
            if (eep_pend) begin
               if (eep_wait == 0) begin eep_done = 1'b1; eep_pend = 1'b0; end
               else eep_wait--;
            end
            if (eep_req) begin eep_pend = 1'b1; eep_wait = eep_dly - 1; end
            if (resp_pend) begin
               if (resp_wait == 0) begin resp_sent = 1'b1; resp_pend = 1'b0; end
               else resp_wait--;
            end
            if (send_resp) begin
               resp_pend = 1'b1;
               resp_wait = int'($urandom_range(resp_max, resp_min)) - 1;
            end
            if (spur_en && gain_seen && !eep_pend && $urandom_range(7, 0) == 0)
               eep_done = 1'b1;
            if (spur_en && !gain_seen && busy && !resp_pend && $urandom_range(3, 0) == 0)
               resp_sent = 1'b1;
         end
      end
   end

   // Bus monitor, sampled mid-cycle after the responders have updated.
   initial begin
      clear_mon();
      forever begin
         @(negedge clk);
         #2;
         if (busy) begin
            busy_cnt++;
            if (ram_ch !== exp_ch) ch_bad++;
         end
         if (eep_req) begin
            if (eep_q.size() == 0) eep_cyc_first = cyc;
            eep_q.push_back(int'(eep_addr));
         end
         if (flopOffset) flop_q.push_back(0);
         if (flopGain) begin flop_q.push_back(1); gain_seen = 1'b1; end
         if (send_resp) begin
            if (!prev_re || int'(ram_addr) != re_addr) send_bad++;
            send_q.push_back(int'(ram_addr));
         end
         prev_re = ram_re;
         if (ram_re) re_addr = int'(ram_addr);
         if (dump_done) begin done_cnt++; done_cyc = cyc; end
         if (dump_err) begin err_cnt++; err_cyc = cyc; end
      end
   end

   // Issue one dump strobe, then scramble every input the sequencer must have latched.
   task automatic start_dump(input logic [1:0] ch, input int wp,
                             input logic [2:0] ga, input logic [2:0] gb, input logic [2:0] gc);
      @(negedge clk);
      dump_ch = ch; wr_ptr = ADDR_W'(wp);
      ch1_AFEgain = ga; ch2_AFEgain = gb; ch3_AFEgain = gc;
      exp_ch = ch; dump_cyc = cyc; dump = 1'b1;
      @(negedge clk);
      dump = 1'b0;
      wr_ptr = ADDR_W'($urandom);
      ch1_AFEgain = 3'($urandom); ch2_AFEgain = 3'($urandom); ch3_AFEgain = 3'($urandom);
      dump_ch = 2'($urandom);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin @(negedge clk); #3; n++; end
      check({tag, "_done_in_time"}, 32'(done_cnt > 0), 32'd1);
   endtask

   task automatic wait_sends(input string tag, input int count, input int budget);
      int n = 0;
      while (send_q.size() < count && n < budget) begin @(negedge clk); #3; n++; end
      check({tag, "_sends_in_time"}, 32'(send_q.size() >= count), 32'd1);
   endtask

   // Compare one finished dump against the reference model.
   task automatic verify_dump(input string tag, input int ch, input int g, input int wp,
                              input int de, input int dr, input bit timed);
      int bad = 0;
      int exp_off = ch * 16 + g * 2;
      check({tag, "_eep_count"}, 32'(eep_q.size()), 32'd2);
      check({tag, "_eep_off_addr"}, 32'(eep_q.size() > 0 ? eep_q[0] : -1), 32'(exp_off));
      check({tag, "_eep_gain_addr"}, 32'(eep_q.size() > 1 ? eep_q[1] : -1), 32'(exp_off + 1));
      check({tag, "_first_eep_latency"}, 32'(eep_cyc_first - dump_cyc), 32'd1);
      check({tag, "_flop_order"},
            32'(flop_q.size() == 2 ? flop_q[0] * 2 + flop_q[1] : -1), 32'd1);
      check({tag, "_send_count"}, 32'(send_q.size()), 32'(DEPTH));
      for (int k = 0; k < send_q.size(); k++)
         if (send_q[k] != (wp + k) % DEPTH) bad++;
      check({tag, "_addr_mismatches"}, 32'(bad), 32'd0);
      check({tag, "_first_addr"}, 32'(send_q.size() > 0 ? send_q[0] : -1), 32'(wp));
      check({tag, "_last_addr"}, 32'(send_q.size() > 0 ? send_q[send_q.size()-1] : -1),
            32'((wp + DEPTH - 1) % DEPTH));
      check({tag, "_send_after_read"}, 32'(send_bad), 32'd0);
      check({tag, "_ram_ch_stable"}, 32'(ch_bad), 32'd0);
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      if (timed)
         check({tag, "_total_cycles"}, 32'(done_cyc - dump_cyc),
               32'(1 + 2 * (1 + de) + DEPTH * (2 + dr)));
      repeat (2) @(negedge clk);
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int wp, g;
      logic [2:0] ga, gb, gc;
      rst = 1'b0; dump = 1'b0; dump_ch = '0; wr_ptr = '0;
      ch1_AFEgain = '0; ch2_AFEgain = '0; ch3_AFEgain = '0; exp_ch = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs_in_reset", out_vec(), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs_after", out_vec(), 32'd0);

      // 1. Happy path: ch2, gain 5, slow handshakes.
      eep_dly = 4; resp_min = 10; resp_max = 10; spur_en = 1'b0;
      clear_mon();
      start_dump(2'd1, 0, 3'd2, 3'b101, 3'd6);
      wait_done("happy", 20000);
      verify_dump("happy", 1, 5, 0, 4, 10, 1'b1);

      // 2. Wrap-around from 500 on ch1, random delays and stray strobes.
      eep_dly = 2; resp_min = 1; resp_max = 3; spur_en = 1'b1;
      ga = 3'($urandom); gb = 3'($urandom); gc = 3'($urandom);
      clear_mon();
      start_dump(2'd0, 500, ga, gb, gc);
      wait_done("wrap", 20000);
      verify_dump("wrap", 0, int'(ga), 500, 0, 0, 1'b0);

      // 3. Reserved channel.
      spur_en = 1'b0;
      clear_mon();
      @(negedge clk);
      dump_ch = 2'd3; dump_cyc = cyc; dump = 1'b1;
      @(negedge clk);
      dump = 1'b0;
      repeat (20) @(negedge clk);
      check("rsvd_err_count", 32'(err_cnt), 32'd1);
      check("rsvd_err_latency", 32'(err_cyc - dump_cyc), 32'd1);
      check("rsvd_busy_cycles", 32'(busy_cnt), 32'd0);
      check("rsvd_eep_reqs", 32'(eep_q.size()), 32'd0);
      check("rsvd_sends", 32'(send_q.size()), 32'd0);

      // 4. Second dump (ch3) while streaming ch1 is ignored.
      eep_dly = 1; resp_min = 3; resp_max = 3;
      wp = int'($urandom_range(DEPTH - 1, 0));
      ga = 3'($urandom); gb = 3'($urandom); gc = 3'($urandom);
      clear_mon();
      start_dump(2'd0, wp, ga, gb, gc);
      wait_sends("busy", 50, 5000);
      @(negedge clk);
      dump_ch = 2'd2; dump = 1'b1;
      @(negedge clk);
      dump = 1'b0;
      wait_done("busy", 20000);
      verify_dump("busy", 0, int'(ga), wp, 1, 3, 1'b1);
      check("busy_no_err", 32'(err_cnt), 32'd0);

      // 5. Reset after 100 sends, then a clean restart.
      eep_dly = 3; resp_min = 1; resp_max = 4; spur_en = 1'b1;
      wp = int'($urandom_range(DEPTH - 1, 0));
      clear_mon();
      start_dump(2'd2, wp, 3'($urandom), 3'($urandom), 3'd7);
      wait_sends("rstmid", 100, 5000);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check("rstmid_outputs_zero", out_vec(), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid_no_done", 32'(done_cnt), 32'd0);
      check("rstmid_idle", 32'(busy), 32'd0);
      wp = int'($urandom_range(DEPTH - 1, 0));
      clear_mon();
      start_dump(2'd2, wp, 3'd1, 3'd2, 3'd3);
      wait_done("restart", 20000);
      verify_dump("restart", 2, 3, wp, 0, 0, 1'b0);

      // 6. Back-to-back handshakes: deterministic total duration.
      eep_dly = 1; resp_min = 1; resp_max = 1; spur_en = 1'b0;
      wp = int'($urandom_range(DEPTH - 1, 0));
      ga = 3'($urandom); gb = 3'($urandom); gc = 3'($urandom);
      g = int'(gb);
      clear_mon();
      start_dump(2'd1, wp, ga, gb, gc);
      wait_done("b2b", 20000);
      verify_dump("b2b", 1, g, wp, 1, 1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_dump_ctrl
